// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage indices, refill-counter width and sequencer state type
package pipe_pkg;
  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_MA = 3;
  localparam int STG_WB = 4;
  localparam int RC_W   = 4;
  typedef enum logic {RUN, FLUSH} pipe_state_t;
endpackage

// File: rtl/pipe_stall_chain.sv
// pipe_stall_chain: combinational stall/clear generation from valid, busy and flush
module pipe_stall_chain #(
  parameter int NSTAGE = 5,
  parameter int FS_W   = $clog2(NSTAGE)
) (
  input  logic [NSTAGE-1:0] valid,
  input  logic [NSTAGE-1:0] busy,
  input  logic              flush_req,
  input  logic [FS_W-1:0]   flush_stage,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] clear
);
  logic [NSTAGE-1:0] raw;
  logic [NSTAGE-1:0] fmask;
  genvar i;
  for (i = 0; i < NSTAGE; i++) begin : g_stg
    assign fmask[i] = flush_req && (int'(flush_stage) >= i);
    if (i == NSTAGE - 1) begin : g_old
      assign raw[i] = busy[i] & valid[i];
    end else begin : g_young
      assign raw[i] = valid[i] & (busy[i] | raw[i+1]);
    end
    // A flushed stage never holds; its squashed slot is reloaded as a bubble.
    assign stall[i] = raw[i] & ~fmask[i];
    if (i == 0) begin : g_head
      assign clear[i] = fmask[i];
    end else begin : g_tail
      assign clear[i] = fmask[i] | (~stall[i] & stall[i-1]);
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/clear/valid sequencer with flush refill window and stall perf counter
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE     = 5,
  parameter int REFILL_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_valid,
  input  logic [NSTAGE-1:0]         busy,
  input  logic                      flush_req,
  input  logic [$clog2(NSTAGE)-1:0] flush_stage,
  input  logic                      perf_clr,
  output logic [NSTAGE-1:0]         stall,
  output logic [NSTAGE-1:0]         clear,
  output logic [NSTAGE-1:0]         valid,
  output logic                      fetch_en,
  output logic                      flushing,
  output logic [CNT_W-1:0]          stall_cnt
);
  localparam logic [RC_W-1:0] RLD = RC_W'(REFILL_CYC - 1);
  pipe_state_t       state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [NSTAGE-1:0] valid_q, valid_d, feed;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  pipe_stall_chain #(.NSTAGE(NSTAGE)) u_chain (
    .valid(valid_q),
    .busy(busy),
    .flush_req(flush_req),
    .flush_stage(flush_stage),
    .stall(stall),
    .clear(clear)
  );
  // Next valid bits, refill FSM and saturating stall counter
  always_comb begin
    fetch_en    = (state_q == RUN) & ~flush_req & ~stall[STG_IF];
    flushing    = state_q == FLUSH;
    feed        = {valid_q[NSTAGE-2:0] & ~stall[NSTAGE-2:0], fetch_valid & fetch_en};
    valid_d     = ~clear & ((stall & valid_q) | (~stall & feed));
    state_d     = flush_req ? FLUSH : (state_q == FLUSH && rcnt_q == '0) ? RUN : state_q;
    rcnt_d      = flush_req ? RLD : (state_q == FLUSH && rcnt_q != '0) ? rcnt_q - 1'b1 : rcnt_q;
    stall_cnt_d = perf_clr ? '0 : (state_q == RUN && stall[STG_IF] && ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      rcnt_q      <= '0;
      valid_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign valid     = valid_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus hand sequences for saturation and async reset
module tb_pipe_ctrl;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       fetch_valid = 0;
  logic [4:0] busy = 0;
  logic       flush_req = 0;
  logic [2:0] flush_stage = 0;
  logic       perf_clr = 0;
  logic [4:0] stall, clear, valid;
  logic       fetch_en, flushing;
  logic [3:0] stall_cnt;
  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl #(.NSTAGE(5), .REFILL_CYC(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .busy(busy),
    .flush_req(flush_req), .flush_stage(flush_stage), .perf_clr(perf_clr),
    .stall(stall), .clear(clear), .valid(valid), .fetch_en(fetch_en),
    .flushing(flushing), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fv;
    logic [4:0] busy;
    logic       fr;
    logic [2:0] fs;
    logic       pc;
    logic [4:0] st, cl, va;
    logic       fe, fl;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[34];

  function automatic vec_t mk(logic fv, logic [4:0] b, logic fr, logic [2:0] fs, logic pc,
                              logic [4:0] st, logic [4:0] cl, logic [4:0] va,
                              logic fe, logic fl, logic [3:0] cnt);
    vec_t v;
    v.fv = fv; v.busy = b; v.fr = fr; v.fs = fs; v.pc = pc;
    v.st = st; v.cl = cl; v.va = va; v.fe = fe; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic fv, logic [4:0] b, logic fr, logic [2:0] fs, logic pc);
    fetch_valid = fv; busy = b; flush_req = fr; flush_stage = fs; perf_clr = pc;
  endtask

  initial begin
    tbl[0]  = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0);
    tbl[1]  = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00001, 1, 0, 0);
    tbl[2]  = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00011, 1, 0, 0);
    tbl[3]  = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00111, 1, 0, 0);
    tbl[4]  = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b01111, 1, 0, 0);
    tbl[5]  = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b11111, 1, 0, 0);
    tbl[6]  = mk(1, 5'b00100, 0, 0, 0, 5'b00111, 5'b01000, 5'b11111, 0, 0, 0);
    tbl[7]  = mk(1, 5'b00100, 0, 0, 0, 5'b00111, 5'b01000, 5'b10111, 0, 0, 1);
    tbl[8]  = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00111, 1, 0, 2);
    tbl[9]  = mk(0, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b01111, 1, 0, 2);
    tbl[10] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b11110, 1, 0, 2);
    tbl[11] = mk(0, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b11101, 1, 0, 2);
    tbl[12] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b11010, 1, 0, 2);
    tbl[13] = mk(1, 5'b10000, 0, 0, 0, 5'b10000, 5'b00000, 5'b10101, 1, 0, 2);
    tbl[14] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b11011, 1, 0, 2);
    tbl[15] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b10111, 1, 0, 2);
    tbl[16] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b01111, 1, 0, 2);
    tbl[17] = mk(1, 5'b00000, 1, 2, 0, 5'b00000, 5'b00111, 5'b11111, 0, 0, 2);
    tbl[18] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b11000, 0, 1, 2);
    tbl[19] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b10000, 0, 1, 2);
    tbl[20] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 2);
    tbl[21] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00001, 1, 0, 2);
    tbl[22] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00011, 1, 0, 2);
    tbl[23] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00111, 1, 0, 2);
    tbl[24] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b01111, 1, 0, 2);
    tbl[25] = mk(1, 5'b00000, 1, 1, 0, 5'b00000, 5'b00011, 5'b11111, 0, 0, 2);
    tbl[26] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b11100, 0, 1, 2);
    tbl[27] = mk(1, 5'b01000, 1, 3, 0, 5'b00000, 5'b01111, 5'b11000, 0, 1, 2);
    tbl[28] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b10000, 0, 1, 2);
    tbl[29] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 2);
    tbl[30] = mk(1, 5'b00000, 1, 7, 0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 2);
    tbl[31] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 2);
    tbl[32] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 2);
    tbl[33] = mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 2);

    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", int'(valid), 0);
    check("reset_cnt", int'(stall_cnt), 0);
    check("reset_flushing", int'(flushing), 0);
    rst_n = 1;

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].fv, tbl[i].busy, tbl[i].fr, tbl[i].fs, tbl[i].pc);
      @(negedge clk);
      check($sformatf("v%0d_stall", i), int'(stall), int'(tbl[i].st));
      check($sformatf("v%0d_clear", i), int'(clear), int'(tbl[i].cl));
      check($sformatf("v%0d_valid", i), int'(valid), int'(tbl[i].va));
      check($sformatf("v%0d_fetch_en", i), int'(fetch_en), int'(tbl[i].fe));
      check($sformatf("v%0d_flushing", i), int'(flushing), int'(tbl[i].fl));
      check($sformatf("v%0d_stall_cnt", i), int'(stall_cnt), int'(tbl[i].cnt));
      @(posedge clk);
      #1;
    end

    drive(1, 5'b00000, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("fill_valid", int'(valid), 5'b11111);
    busy = 5'b10000;
    repeat (20) @(posedge clk);
    #1;
    check("sat_stall", int'(stall), 5'b11111);
    check("sat_fetch_en", int'(fetch_en), 0);
    check("sat_cnt", int'(stall_cnt), 15);
    perf_clr = 1;
    @(posedge clk);
    #1;
    check("perf_clr_cnt", int'(stall_cnt), 0);
    perf_clr = 0;
    @(posedge clk);
    #1;
    check("post_clr_cnt", int'(stall_cnt), 1);
    drive(1, 5'b00000, 1, 7, 0);
    @(posedge clk);
    #1;
    flush_req = 0;
    check("preflush_flushing", int'(flushing), 1);
    check("preflush_fetch_en", int'(fetch_en), 0);
    check("preflush_valid", int'(valid), 0);
    #2;
    rst_n = 0;
    #1;
    check("async_valid", int'(valid), 0);
    check("async_flushing", int'(flushing), 0);
    check("async_fetch_en", int'(fetch_en), 1);
    check("async_cnt", int'(stall_cnt), 0);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    check("post_rst_flushing", int'(flushing), 0);
    check("post_rst_fetch_en", int'(fetch_en), 1);
    check("post_rst_valid", int'(valid), 5'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/clear/valid sequencer for the in-order N-stage core pipeline (default IF, ID, EX, MA, WB).
- Drives the stall and clear inputs of every stage's pipeline register.
- Tracks per-stage valid bits, squashes bubbles, inserts bubbles behind busy stages, and executes redirect flushes with a refill window.
- Also keeps a saturating front-end stall-cycle counter for perf.

Parameters:
NSTAGE, 5, number of pipeline stages; index 0 = youngest (IF), NSTAGE-1 = oldest (WB)
REFILL_CYC, 2, cycles fetch is held off after a flush (1..15)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
fetch_valid  input  1  IF has an instruction to inject into stage 0
busy  input  NSTAGE  stage i cannot complete this cycle (ignored when valid[i]=0)
flush_req  input  1  redirect: squash stages 0..flush_stage
flush_stage  input  $clog2(NSTAGE)  oldest stage squashed by flush_req
perf_clr  input  1  synchronous clear of stall_cnt
stall  output  NSTAGE  hold pipeline register i
clear  output  NSTAGE  load INIT into pipeline register i (bubble/flush); overrides stall
valid  output  NSTAGE  registered valid bit of stage i
fetch_en  output  1  IF may fetch this cycle
flushing  output  1  FSM in FLUSH state
stall_cnt  output  CNT_W  saturating count of RUN cycles with stall[0]=1

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: valid=0, state=RUN, refill counter=0, stall_cnt=0. fetch_en=1 and flushing=0 once reset releases.
- stall, clear and fetch_en are combinational from registered state and inputs. valid and stall_cnt are registered.
- Effective busy: eb[i] = busy[i] & valid[i].
- Stall chain, evaluated oldest to youngest:
  - stall[NSTAGE-1] = eb[NSTAGE-1]
  - stall[i] = eb[i] | (valid[i] & stall[i+1])
  - An invalid stage never stalls. It accepts new content even when the next stage is stalled (bubble squash).
- Bubble insert: for i>0, clear[i]=1 when stall[i]=0 and stall[i-1]=1.
- Valid update:
  - stage i>0 not stalled: valid[i] <= valid[i-1] & ~stall[i-1]
  - stage 0 not stalled: valid[0] <= fetch_valid & fetch_en
  - stalled stage holds its valid bit.
- Flush:
  - flush_req=1 forces clear[j]=1 and valid[j]<=0 for all j<=flush_stage, in the same cycle.
  - Flush overrides stall for those stages.
  - Stages older than flush_stage follow the normal rules.
  - flush_stage >= NSTAGE squashes all stages.
- FSM:
  - RUN: flush_req -> FLUSH, refill counter <= REFILL_CYC-1.
  - FLUSH: fetch_en=0, flushing=1; counter decrements each cycle; at 0 -> RUN.
  - flush_req while in FLUSH reloads the counter to REFILL_CYC-1 (restart) and squashes again.
- fetch_en = (state==RUN) & ~flush_req & ~stall[0].
- stall_cnt:
  - increments when state==RUN & stall[0]; saturates at all-ones.
  - perf_clr has priority over increment.
- Simultaneous busy and flush on the same stage: flush wins.
- busy on an invalid stage has no effect.
- Reset mid-operation: all state returns to reset values immediately (async).

Decomposition:
- Shared package pipe_pkg:
  - stage index constants (STG_IF=0, STG_ID=1, STG_EX=2, STG_MA=3, STG_WB=4)
  - typedef enum logic {RUN, FLUSH} pipe_state_t
- Sub-module pipe_stall_chain: purely combinational. Computes stall/clear from valid, busy, flush_req and flush_stage via a generate loop. pipe_ctrl owns all registers and the FSM.

Test Plan (NSTAGE=5, REFILL_CYC=2):
1. Free flow: fetch_valid=1 for 6 cycles from reset, busy=0 -> valid walks 00001, 00011, 00111, 01111, 11111; stall=0; clear=0.
2. EX busy: full pipe, busy[2]=1 for 2 cycles -> stall=00111, clear[3]=1 on both cycles, valid[3]=0 then valid[4]=0 following. busy drops -> stall=0. stall_cnt=2.
3. Bubble squash: valid=10101, busy[4]=1 -> stall=10000. Stages 1 and 3 load (bubbles closed). Next valid[3]=1, valid[1]=1 (from stage 0).
4. Flush: full pipe, flush_req=1 with flush_stage=2 -> clear=00111 that cycle, next valid=11000. fetch_en=0 and flushing=1 for 2 cycles, then fetch_en=1.
5. Re-flush: flush_req again in the 2nd FLUSH cycle -> FLUSH extended; fetch_en=0 for 2 further cycles. flush_stage=3 while busy[3]=1 -> stage 3 cleared despite busy.
6. Saturation and reset: CNT_W=4, stall[0] held 20 cycles -> stall_cnt=15. perf_clr together with stall -> 0. rst_n pulsed low mid-FLUSH -> valid=0, state RUN, fetch_en=1 after release.
